zxuno_reg_port: RTL and testbench

ZXUNO_REG_PORT -- requirements
Module: zxuno_reg_port

---
 rtl/zxuno_reg_port.sv | 122 ++++++++++++
 tb/tb_zxuno_reg_port.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zxuno_reg_port.sv
// ZX-UNO register port: a two-port indirect register interface on the Z80 I/O bus.
// A write to ADDR_PORT selects a register number. A write to DATA_PORT produces a
// one-cycle write strobe for the selected register. Reads of DATA_PORT raise a read
// level. Reads of ADDR_PORT return the selected register number.
//
// Ports:
//   clk, rst_n       system clock; asynchronous active-low reset
//   a, din           Z80 address and write data (stable while strobes are active)
//   iorq_n, rd_n,
//   wr_n, m1_n       Z80 bus strobes, asynchronous to clk
//   zxuno_addr       selected register number (registered)
//   zxuno_regrd      high while a DATA_PORT read is in progress
//   zxuno_regwr      one-cycle pulse per DATA_PORT write
//   regaddr_changed  one-cycle pulse per ADDR_PORT write
//   dout, oe         readback of zxuno_addr and its output enable for ADDR_PORT reads
//
// ADDR_PORT and DATA_PORT must differ.
module zxuno_reg_port #(
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [7:0]  din,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic        regaddr_changed,
  output logic [7:0]  dout,
  output logic        oe
);

  // Two-flop synchronizers; bit 1 is the synchronized value.
  logic [1:0] iorq_sync, rd_sync, wr_sync, m1_sync;
  logic       iorq_s, rd_s, wr_s, m1_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iorq_sync <= 2'b11;
      rd_sync   <= 2'b11;
      wr_sync   <= 2'b11;
      m1_sync   <= 2'b11;
    end else begin
      iorq_sync <= {iorq_sync[0], iorq_n};
      rd_sync   <= {rd_sync[0], rd_n};
      wr_sync   <= {wr_sync[0], wr_n};
      m1_sync   <= {m1_sync[0], m1_n};
    end
  end

  assign iorq_s = iorq_sync[1];
  assign rd_s   = rd_sync[1];
  assign wr_s   = wr_sync[1];
  assign m1_s   = m1_sync[1];

  // Interrupt acknowledge (IORQ with M1 low) is never decoded as an I/O access.
  logic io_rd, io_wr;
  assign io_rd = !iorq_s && !rd_s && m1_s;
  assign io_wr = !iorq_s && !wr_s && m1_s;

  logic hit_addr, hit_data;
  assign hit_addr = (a == ADDR_PORT);
  assign hit_data = (a == DATA_PORT);

  // After reset the synchronizers still hold their reset value of 1 for two cycles,
  // which would hide a strobe that is already active. armed[1] becomes set only once
  // both stages hold real samples, so WAIT cannot be left on stale idle values.
  logic [1:0] armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 2'b00;
    end else begin
      armed <= {armed[0], 1'b1};
    end
  end

  typedef enum logic [0:0] {StIdle, StWait} state_e;
  state_e state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= StWait;
      zxuno_addr      <= 8'h00;
      zxuno_regwr     <= 1'b0;
      regaddr_changed <= 1'b0;
    end else begin
      zxuno_regwr     <= 1'b0;
      regaddr_changed <= 1'b0;
      unique case (state)
        StIdle: begin
          if (io_wr) begin
            state <= StWait;
            if (hit_addr) begin
              zxuno_addr      <= din;
              regaddr_changed <= 1'b1;
            end else if (hit_data) begin
              zxuno_regwr <= 1'b1;
            end
          end
        end
        StWait: begin
          if (!io_wr && !io_rd && armed[1]) begin
            state <= StIdle;
          end
        end
        default: state <= StWait;
      endcase
    end
  end

  // Read decode is independent of the FSM so it tracks the whole strobe.
  assign zxuno_regrd = io_rd && hit_data;
  assign oe          = io_rd && hit_addr;
  assign dout        = zxuno_addr;

endmodule

// File: tb/tb_zxuno_reg_port.sv
module tb_zxuno_reg_port;
  localparam logic [15:0] AP = 16'hFC3B;
  localparam logic [15:0] DP = 16'hFD3B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'h0000;
  logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [7:0]  zxuno_addr, dout;
  logic        zxuno_regrd, zxuno_regwr, regaddr_changed, oe;

  int checks = 0;
  int fails  = 0;

  // Behavioural reference: selected register number and expected pulse totals.
  logic [7:0] model_addr = 8'h00;
  int exp_rac = 0;
  int exp_rw  = 0;

  // Observed pulse totals, plus exclusivity violations.
  int n_rac = 0, n_rw = 0, n_overlap = 0;

  always #5 clk = ~clk;

  zxuno_reg_port dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .a               (a),
    .iorq_n          (iorq_n),
    .rd_n            (rd_n),
    .wr_n            (wr_n),
    .m1_n            (m1_n),
    .din             (din),
    .zxuno_addr      (zxuno_addr),
    .zxuno_regrd     (zxuno_regrd),
    .zxuno_regwr     (zxuno_regwr),
    .regaddr_changed (regaddr_changed),
    .dout            (dout),
    .oe              (oe)
  );

  always @(negedge clk) begin
    if (regaddr_changed) n_rac++;
    if (zxuno_regwr) n_rw++;
    if ((regaddr_changed && zxuno_regwr) || (oe && zxuno_regrd)) n_overlap++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a bus write for len clocks, release, then leave gap idle clocks.
  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data, input int len,
                           input logic m1, input int gap);
    @(negedge clk);
    a = addr; din = data; m1_n = m1; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (len) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    idle(2);
    checks++;
    if (zxuno_addr !== 8'h00 || dout !== 8'h00 || zxuno_regrd !== 1'b0 ||
        zxuno_regwr !== 1'b0 || regaddr_changed !== 1'b0 || oe !== 1'b0) begin
      fails++;
      $display("FAIL reset: addr=%h dout=%h rd=%b wr=%b rac=%b oe=%b, required all zero",
               zxuno_addr, dout, zxuno_regrd, zxuno_regwr, regaddr_changed, oe);
    end
    rst_n = 1'b1;
    idle(4);
    checks++;
    if (n_rac != 0 || n_rw != 0) begin
      fails++;
      $display("FAIL reset_idle: rac=%0d rw=%0d pulses, required 0", n_rac, n_rw);
    end
  endtask

  task automatic test_select_write();
    int base = n_rac;
    @(negedge clk);
    a = AP; din = 8'hFF; iorq_n = 1'b0; wr_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (regaddr_changed !== (k == 3)) begin
        fails++;
        $display("FAIL select_pulse k=%0d: rac=%b required %b", k, regaddr_changed, k == 3);
      end
    end
    iorq_n = 1'b1; wr_n = 1'b1;
    idle(4);
    model_addr = 8'hFF; exp_rac++;
    checks++;
    if (n_rac - base != 1 || zxuno_addr !== model_addr || dout !== model_addr) begin
      fails++;
      $display("FAIL select_result: pulses=%0d addr=%h dout=%h, required 1 %h %h",
               n_rac - base, zxuno_addr, dout, model_addr, model_addr);
    end
  endtask

  task automatic test_data_write();
    int base = n_rw;
    @(negedge clk);
    a = DP; din = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (zxuno_regwr !== (k == 3) || regaddr_changed !== 1'b0 || zxuno_addr !== model_addr) begin
        fails++;
        $display("FAIL data_pulse k=%0d: regwr=%b rac=%b addr=%h, required %b 0 %h",
                 k, zxuno_regwr, regaddr_changed, zxuno_addr, k == 3, model_addr);
      end
    end
    iorq_n = 1'b1; wr_n = 1'b1;
    idle(4);
    exp_rw++;
    checks++;
    if (n_rw - base != 1) begin
      fails++;
      $display("FAIL data_count: pulses=%0d required 1", n_rw - base);
    end
  endtask

  // Read strobe held for 6 clk; level expected on samples 2..7.
  task automatic test_read();
    for (int p = 0; p < 2; p++) begin
      logic [15:0] ra;
      ra = (p == 0) ? DP : AP;
      @(negedge clk);
      a = ra; iorq_n = 1'b0; rd_n = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        logic want;
        @(negedge clk);
        want = (k >= 2 && k <= 7);
        checks++;
        if (zxuno_regrd !== (want && p == 0) || oe !== (want && p == 1) ||
            dout !== model_addr) begin
          fails++;
          $display("FAIL read_%s k=%0d: regrd=%b oe=%b dout=%h, required %b %b %h",
                   p == 0 ? "data" : "addr", k, zxuno_regrd, oe, dout,
                   want && p == 0, want && p == 1, model_addr);
        end
        if (k == 6) begin
          iorq_n = 1'b1; rd_n = 1'b1;
        end
      end
    end
  endtask

  task automatic test_inta();
    int b_rac = n_rac;
    int b_rw = n_rw;
    bus_write(AP, 8'h12, 6, 1'b0, 4);
    bus_write(DP, 8'h34, 6, 1'b0, 4);
    checks++;
    if (n_rac != b_rac || n_rw != b_rw || zxuno_addr !== model_addr) begin
      fails++;
      $display("FAIL inta: rac=%0d rw=%0d addr=%h, required 0 0 %h",
               n_rac - b_rac, n_rw - b_rw, zxuno_addr, model_addr);
    end
  endtask

  task automatic test_reset_mid();
    int b_rac;
    @(negedge clk);
    a = AP; din = 8'h77; iorq_n = 1'b0; wr_n = 1'b0;
    idle(4);
    rst_n = 1'b0;
    idle(2);
    model_addr = 8'h00;
    checks++;
    if (zxuno_addr !== 8'h00 || regaddr_changed !== 1'b0 || oe !== 1'b0 || dout !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid: addr=%h rac=%b oe=%b dout=%h, required 00 0 0 00",
               zxuno_addr, regaddr_changed, oe, dout);
    end
    b_rac = n_rac;
    rst_n = 1'b1;
    idle(8);
    iorq_n = 1'b1; wr_n = 1'b1;
    idle(4);
    checks++;
    if (n_rac != b_rac || zxuno_addr !== 8'h00) begin
      fails++;
      $display("FAIL reset_release: rac=%0d addr=%h, required 0 00", n_rac - b_rac, zxuno_addr);
    end
    // Counters are rebased: the pre-reset pulse is not part of this scenario's model.
    exp_rac = n_rac; exp_rw = n_rw;
    bus_write(AP, 8'h33, 4, 1'b1, 3);
    model_addr = 8'h33; exp_rac++;
    checks++;
    if (n_rac != exp_rac || zxuno_addr !== model_addr) begin
      fails++;
      $display("FAIL reset_newwrite: rac=%0d addr=%h, required %0d %h",
               n_rac, zxuno_addr, exp_rac, model_addr);
    end
  endtask

  task automatic test_back_to_back();
    int b_rac = n_rac;
    int b_rw = n_rw;
    bus_write(AP, 8'hC4, 4, 1'b1, 2);
    bus_write(DP, 8'h99, 4, 1'b1, 2);
    bus_write(16'h00FE, 8'h11, 4, 1'b1, 5);
    model_addr = 8'hC4; exp_rac++; exp_rw++;
    checks++;
    if (n_rac - b_rac != 1 || n_rw - b_rw != 1 || zxuno_addr !== model_addr) begin
      fails++;
      $display("FAIL back_to_back: rac=%0d rw=%0d addr=%h, required 1 1 %h",
               n_rac - b_rac, n_rw - b_rw, zxuno_addr, model_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [15:0] addr;
      logic [7:0]  data;
      logic        m1;
      int          sel, len, gap;
      sel = $urandom_range(0, 3);
      addr = (sel == 0) ? AP : (sel == 1) ? DP : 16'($urandom);
      if (sel == 3) addr = AP ^ 16'h0100 ^ 16'($urandom_range(0, 255));
      data = 8'($urandom);
      len  = $urandom_range(3, 8);
      gap  = $urandom_range(2, 4);
      m1   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        a = addr; iorq_n = 1'b0; rd_n = 1'b0; m1_n = m1;
        idle(3);
        checks++;
        if (oe !== (m1 && addr == AP) || zxuno_regrd !== (m1 && addr == DP) ||
            dout !== model_addr) begin
          fails++;
          $display("FAIL rand_read %0d a=%h m1=%b: oe=%b regrd=%b dout=%h, required %b %b %h",
                   i, addr, m1, oe, zxuno_regrd, dout, m1 && addr == AP, m1 && addr == DP,
                   model_addr);
        end
        iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
        idle(gap);
      end else begin
        bus_write(addr, data, len, m1, gap);
        if (m1 && addr == AP) begin
          model_addr = data; exp_rac++;
        end else if (m1 && addr == DP) begin
          exp_rw++;
        end
        checks++;
        if (n_rac != exp_rac || n_rw != exp_rw || zxuno_addr !== model_addr) begin
          fails++;
          $display("FAIL rand_write %0d a=%h m1=%b: rac=%0d rw=%0d addr=%h, required %0d %0d %h",
                   i, addr, m1, n_rac, n_rw, zxuno_addr, exp_rac, exp_rw, model_addr);
        end
      end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (n_overlap != 0) begin
      fails++;
      $display("FAIL exclusive: %0d overlapping cycles, required 0", n_overlap);
    end
  endtask

  initial begin
    test_reset();
    test_select_write();
    test_data_write();
    test_read();
    test_inta();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
